// File: rtl/multi_chan_handshake_arb_if.sv
// ----------------------------------------------------------------------------
// multi_chan_handshake_arb_if
//
// Purpose: bundles the source-side request/acknowledge signals and the
// consumer-side valid/ready stream of multi_chan_handshake_arb.
//
// Signals:
//   vld_in   [NUM_CH]             per-channel request, held with din
//   din      [NUM_CH*DATA_WIDTH]  channel i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   rdy_out  [NUM_CH]             one-cycle acknowledge per channel
//   vld_out                       FIFO head valid
//   dout     [DATA_WIDTH]         FIFO head payload
//   ch_out   [CH_W]               FIFO head source channel
//   rdy_in                        consumer ready
//   fifo_lvl [LVL_W]              FIFO occupancy 0..DEPTH
//
// Modports:
//   master - sources plus consumer (drives vld_in/din/rdy_in)
//   slave  - the arbiter itself
// ----------------------------------------------------------------------------
interface multi_chan_handshake_arb_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 4
);
    localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]            vld_in;
    logic [NUM_CH*DATA_WIDTH-1:0] din;
    logic [NUM_CH-1:0]            rdy_out;
    logic                         vld_out;
    logic [DATA_WIDTH-1:0]        dout;
    logic [CH_W-1:0]              ch_out;
    logic                         rdy_in;
    logic [LVL_W-1:0]             fifo_lvl;

    modport master (
        output vld_in,
        output din,
        output rdy_in,
        input  rdy_out,
        input  vld_out,
        input  dout,
        input  ch_out,
        input  fifo_lvl
    );

    modport slave (
        input  vld_in,
        input  din,
        input  rdy_in,
        output rdy_out,
        output vld_out,
        output dout,
        output ch_out,
        output fifo_lvl
    );
endinterface

// File: rtl/multi_chan_handshake_arb.sv
// ----------------------------------------------------------------------------
// multi_chan_handshake_arb
//
// Purpose: merges NUM_CH held-request / pulse-acknowledge source channels into
// one valid/ready stream. A round-robin arbiter picks at most one eligible
// channel per cycle and writes {channel, payload} into a DEPTH-entry
// first-word-fall-through FIFO; the FIFO head is presented to the consumer.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - multi_chan_handshake_arb_if.slave (vld_in, din, rdy_out, vld_out,
//          dout, ch_out, rdy_in, fifo_lvl)
//
// Build option:
//   MULTI_CHAN_HS_ARB_FIXED_PRIO_EN - when defined, the lowest-index eligible
//   channel always wins and no last-grant pointer is kept. Default (undefined)
//   is round-robin starting after the last granted channel.
// ----------------------------------------------------------------------------
module multi_chan_handshake_arb #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 4
) (
    input logic                        clk,
    input logic                        rst,
    multi_chan_handshake_arb_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);

    // FIFO storage and control
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [CH_W-1:0]       mem_ch   [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      lvl_q;

    // Registered acknowledge (one cycle after the grant)
    logic [NUM_CH-1:0]     rdy_p1;

    // Grant decision of the current cycle
    logic                  grant_p0;
    logic [CH_W-1:0]       grant_ch_p0;
    logic [NUM_CH-1:0]     grant_oh_p0;
    logic [DATA_WIDTH-1:0] grant_data_p0;

    logic [NUM_CH-1:0]     elig;
    logic                  can_push;
    logic                  pop;

`ifndef MULTI_CHAN_HS_ARB_FIXED_PRIO_EN
    logic [CH_W-1:0]       last_grant;
`endif

    // A channel acknowledged this cycle still shows its old word, so it must
    // sit out one cycle to avoid capturing the same word twice.
    assign elig = bus.vld_in & ~rdy_p1;

    // Only the occupancy at the start of the cycle counts; a concurrent pop
    // does not open a slot for this cycle's grant.
    assign can_push = (lvl_q < LVL_W'(DEPTH));
    assign pop      = (lvl_q != '0) && bus.rdy_in;

    // ---- stage p0: arbitration ----
    always_comb begin : arb_pick
        int idx;
        grant_p0      = 1'b0;
        grant_ch_p0   = '0;
        grant_oh_p0   = '0;
        grant_data_p0 = '0;
        idx           = 0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef MULTI_CHAN_HS_ARB_FIXED_PRIO_EN
            idx = k;
`else
            // Search begins one past the last winner and wraps around.
            idx = (int'(last_grant) + 1 + k) % NUM_CH;
`endif
            if (!grant_p0 && can_push && elig[idx]) begin
                grant_p0           = 1'b1;
                grant_ch_p0        = idx[CH_W-1:0];
                grant_oh_p0[idx]   = 1'b1;
                grant_data_p0      = bus.din[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ---- stage p1: acknowledge, FIFO write, occupancy ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_p1 <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl_q  <= '0;
            // Storage is cleared so that dout reads zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_ch[i]   <= '0;
            end
        end else begin
            rdy_p1 <= grant_oh_p0;
            if (grant_p0) begin
                mem_data[wr_ptr] <= grant_data_p0;
                mem_ch[wr_ptr]   <= grant_ch_p0;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant_p0, pop})
                2'b10:   lvl_q <= lvl_q + 1'b1;
                2'b01:   lvl_q <= lvl_q - 1'b1;
                default: lvl_q <= lvl_q;
            endcase
        end
    end

`ifndef MULTI_CHAN_HS_ARB_FIXED_PRIO_EN
    // Reset value NUM_CH-1 puts channel 0 first in line after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (grant_p0) begin
            last_grant <= grant_ch_p0;
        end
    end
`endif

    assign bus.rdy_out  = rdy_p1;
    assign bus.vld_out  = (lvl_q != '0);
    assign bus.dout     = mem_data[rd_ptr];
    assign bus.ch_out   = mem_ch[rd_ptr];
    assign bus.fifo_lvl = lvl_q;

endmodule

// File: tb/tb_multi_chan_handshake_arb.sv
// ----------------------------------------------------------------------------
// tb_multi_chan_handshake_arb
//
// Directed bench for multi_chan_handshake_arb (default round-robin build,
// NUM_CH=4, DEPTH=4, DATA_WIDTH=16). A vector table covers reset, a single
// word, round-robin fairness, full FIFO, withdrawn request and push/pop at
// constant level; hand-written sequences cover reset mid-stream and a long
// wrap-around run.
// ----------------------------------------------------------------------------
module tb_multi_chan_handshake_arb;
    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int DEP = 4;
    localparam int NV  = 24;

    logic clk;
    logic rst;

    multi_chan_handshake_arb_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP)) bus ();

    multi_chan_handshake_arb #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic        rdy_in;
        logic [3:0]  e_rdy;
        logic        e_vld;
        logic [15:0] e_dout;
        logic [1:0]  e_ch;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t        tv [NV];
    logic [15:0] wd [4];
    int          checks;
    int          errors;
    int          acks0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        acks0  = 0;
        wd[0] = 16'h1111;
        wd[1] = 16'h2222;
        wd[2] = 16'hA5A5;
        wd[3] = 16'h4444;

        //           rst   vld      rdy   e_rdy    e_vld e_dout    e_ch  e_lvl
        tv[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 3'd0};
        tv[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'hA5A5, 2'd2, 3'd1};
        tv[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 3'd0};
        tv[3]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 3'd0};
        tv[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0, 3'd1};
        tv[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'h2222, 2'd1, 3'd1};
        tv[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hA5A5, 2'd2, 3'd1};
        tv[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'h4444, 2'd3, 3'd1};
        tv[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'h1111, 2'd0, 3'd1};
        tv[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 16'h1111, 2'd0, 3'd2};
        tv[10] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 16'h1111, 2'd0, 3'd3};
        tv[11] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 16'h1111, 2'd0, 3'd4};
        tv[12] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0, 3'd4};
        tv[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h1111, 2'd0, 3'd4};
        tv[14] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 16'h2222, 2'd1, 3'd3};
        tv[15] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 16'h2222, 2'd1, 3'd4};
        tv[16] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'h2222, 2'd1, 3'd4};
        tv[17] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 16'h2222, 2'd1, 3'd4};
        tv[18] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'h2222, 2'd1, 3'd4};
        tv[19] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 16'hA5A5, 2'd2, 3'd3};
        tv[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 16'h4444, 2'd3, 3'd2};
        tv[21] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'h1111, 2'd0, 3'd2};
        tv[22] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 16'h2222, 2'd1, 3'd1};
        tv[23] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 3'd0};

        rst        = 1'b1;
        bus.vld_in = '0;
        bus.rdy_in = 1'b0;
        bus.din    = {wd[3], wd[2], wd[1], wd[0]};

        // Table-driven vectors
        for (int v = 0; v < NV; v++) begin
            rst        = tv[v].rst;
            bus.vld_in = tv[v].vld;
            bus.rdy_in = tv[v].rdy_in;
            tick();
            chk("rdy_out",  v, 32'(bus.rdy_out),  32'(tv[v].e_rdy));
            chk("vld_out",  v, 32'(bus.vld_out),  32'(tv[v].e_vld));
            chk("fifo_lvl", v, 32'(bus.fifo_lvl), 32'(tv[v].e_lvl));
            if (tv[v].e_vld || tv[v].rst) begin
                chk("dout",   v, 32'(bus.dout),   32'(tv[v].e_dout));
                chk("ch_out", v, 32'(bus.ch_out), 32'(tv[v].e_ch));
            end
        end

        // Reset mid-stream: fill to level 3 with an acknowledge pending
        rst        = 1'b0;
        bus.rdy_in = 1'b0;
        bus.vld_in = 4'b1110;
        tick();
        chk("mid_rdy_a", 0, 32'(bus.rdy_out), 32'h4);
        tick();
        chk("mid_rdy_b", 0, 32'(bus.rdy_out), 32'h8);
        tick();
        chk("mid_rdy_c", 0, 32'(bus.rdy_out), 32'h2);
        chk("mid_lvl_c", 0, 32'(bus.fifo_lvl), 32'd3);
        rst        = 1'b1;
        bus.vld_in = 4'b0001;
        tick();
        chk("rst_rdy",  0, 32'(bus.rdy_out),  32'h0);
        chk("rst_vld",  0, 32'(bus.vld_out),  32'h0);
        chk("rst_lvl",  0, 32'(bus.fifo_lvl), 32'h0);
        chk("rst_dout", 0, 32'(bus.dout),     32'h0);
        chk("rst_ch",   0, 32'(bus.ch_out),   32'h0);
        rst = 1'b0;
        tick();
        chk("rel_rdy",  0, 32'(bus.rdy_out),  32'h1);
        chk("rel_dout", 0, 32'(bus.dout),     32'h1111);
        chk("rel_ch",   0, 32'(bus.ch_out),   32'h0);
        chk("rel_lvl",  0, 32'(bus.fifo_lvl), 32'd1);
        acks0 += int'(bus.rdy_out[0]);
        tick();
        acks0 += int'(bus.rdy_out[0]);
        bus.vld_in = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            acks0 += int'(bus.rdy_out[0]);
        end
        chk("ch0_acks", 0, 32'(acks0), 32'd1);
        chk("hold_lvl", 0, 32'(bus.fifo_lvl), 32'd1);

        // Sustained round-robin with pops, wrapping the pointers three times
        bus.vld_in = 4'b1111;
        bus.rdy_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("wrap_ch",   k, 32'(bus.ch_out),   32'((k + 1) % 4));
            chk("wrap_dout", k, 32'(bus.dout),     32'(wd[(k + 1) % 4]));
            chk("wrap_rdy",  k, 32'(bus.rdy_out),  32'(1 << ((k + 1) % 4)));
            chk("wrap_lvl",  k, 32'(bus.fifo_lvl), 32'd1);
        end
        bus.vld_in = 4'b0000;
        tick();
        chk("drain_lvl", 0, 32'(bus.fifo_lvl), 32'd0);
        chk("drain_vld", 0, 32'(bus.vld_out),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
